// File: rtl/unified_buffer_banked_pkg.sv
// ub_pkg: shared defaults, word type and modulo-DEPTH address helper for the banked unified buffer.
package ub_pkg;

    localparam int UB_DATA_W = 32;
    localparam int UB_VEC    = 2;
    localparam int UB_DEPTH  = 16;

    typedef logic [UB_DATA_W-1:0] ub_word_t;

    // Explicit modulo so non-power-of-two depths wrap correctly.
    function automatic int unsigned ub_wrap(input int unsigned base, input int unsigned off,
                                            input int unsigned depth);
        return (base + off) % depth;
    endfunction

endpackage

// File: rtl/unified_buffer_banked_arbiter.sv
// ub_rr_arbiter: one-hot round-robin grant; the pointer moves past the winner only when a transfer happens.
module ub_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = N > 1 ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d, win, idx;

    always_comb begin
        win = ptr_q;
        idx = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (req_i[idx]) win = idx;
        end
        grant_o = (|req_i) ? N'(1) << win : '0;
        ptr_d   = advance_i ? PW'((int'(win) + 1) % N) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/unified_buffer_banked.sv
// unified_buffer_banked: N_SRC-channel arbitrated vector store into a DEPTH-word memory
// with a registered read-first vector read port and per-word written flags.
module unified_buffer_banked
    import ub_pkg::*;
#(
    parameter int DATA_W    = UB_DATA_W,
    parameter int VEC       = UB_VEC,
    parameter int N_SRC     = 2,
    parameter int DEPTH     = UB_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter bit FIXED_MAP = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [N_SRC-1:0]            store_req,
    input  logic [N_SRC*ADDR_W-1:0]     store_addr,
    input  logic [N_SRC*VEC*DATA_W-1:0] store_data,
    output logic [N_SRC-1:0]            store_ack,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [VEC*DATA_W-1:0]       rd_data,
    output logic                        rd_valid,
    output logic                        rd_written,
    output logic                        busy
);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0]      wr_q, wr_d;
    logic [VEC*DATA_W-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_written_q, rd_written_d;
    logic [N_SRC-1:0]      grant;
    logic [ADDR_W-1:0]     wa, ra;

    ub_rr_arbiter #(.N(N_SRC)) u_arb (
        .clk      (clk),
        .rst_n    (reset),
        .req_i    (store_req),
        .advance_i(|store_ack),
        .grant_o  (grant)
    );

    assign store_ack = clear ? '0 : grant;
    assign busy      = |store_req;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        wa    = '0;
        for (int s = 0; s < N_SRC; s++)
            for (int i = 0; i < VEC; i++)
                if (store_ack[s]) begin
                    wa = ADDR_W'(ub_wrap(FIXED_MAP ? 32'(s * VEC) : 32'(store_addr[s*ADDR_W +: ADDR_W]),
                                         i, DEPTH));
                    mem_d[wa] = store_data[(s*VEC+i)*DATA_W +: DATA_W];
                    wr_d[wa]  = 1'b1;
                end
        if (clear) begin
            for (int d = 0; d < DEPTH; d++) mem_d[d] = '0;
            wr_d = '0;
        end
    end

    // Reads sample the current (pre-write, pre-clear) state: read-first.
    always_comb begin
        rd_data_d    = rd_data_q;
        rd_written_d = rd_written_q;
        ra           = '0;
        if (rd_en) begin
            rd_written_d = 1'b1;
            for (int i = 0; i < VEC; i++) begin
                ra = ADDR_W'(ub_wrap(32'(rd_addr), i, DEPTH));
                rd_data_d[i*DATA_W +: DATA_W] = mem_q[ra];
                rd_written_d &= wr_q[ra];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
            wr_q         <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_written_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_q         <= wr_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_en;
            rd_written_q <= rd_written_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_written = rd_written_q;

endmodule
